// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller and its event counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_t;

  localparam logic [7:0] FLAG_START = 8'h01;
  localparam logic [7:0] FLAG_PAUSE = 8'h02;
  localparam logic [7:0] FLAG_STOP  = 8'h04;

  function automatic logic [7:0] flags_for(input sw_state_t s);
    case (s)
      RUNNING: flags_for = FLAG_START;
      PAUSED:  flags_for = FLAG_PAUSE;
      default: flags_for = FLAG_STOP;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus level debouncer with a one-cycle press pulse on
// each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          r_s1, r_s2;
  logic          r_level, r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      // Any sample agreeing with the current level restarts the window.
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= r_s2;
        r_press <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch command sequencer: debounced buttons drive a start/pause/clear FSM,
// a run-time prescaler producing count ticks, and a lap-freeze display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_a,
  input  logic        btn_b,
  input  logic [15:0] cnt_events,
  output logic [7:0]  flags,
  output logic        active_event,
  output logic [15:0] disp_value,
  output logic        lap_active,
  output logic [1:0]  state_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic w_press_a, w_press_b;
  logic w_lvl_a, w_lvl_b;
  logic w_unused_lvl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_a),
    .o_level (w_lvl_a),
    .o_press (w_press_a)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_b),
    .o_level (w_lvl_b),
    .o_press (w_press_b)
  );

  assign w_unused_lvl = w_lvl_a ^ w_lvl_b;

  sw_state_t     r_state, w_next;
  logic [7:0]    r_flags;
  logic          r_lap;
  logic [15:0]   r_lap_val;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          w_lap_set, w_lap_clr;

  // press_a takes priority; a coincident press_b is dropped entirely.
  always_comb begin
    w_next    = r_state;
    w_lap_set = 1'b0;
    w_lap_clr = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press_a) w_next = RUNNING;
      end
      RUNNING: begin
        if (w_press_a) begin
          w_next = PAUSED;
        end else if (w_press_b) begin
          if (r_lap) w_lap_clr = 1'b1;
          else       w_lap_set = 1'b1;
        end
      end
      PAUSED: begin
        if (w_press_a) begin
          w_next = RUNNING;
        end else if (w_press_b) begin
          w_next    = IDLE;
          w_lap_clr = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_flags   <= FLAG_STOP;
      r_lap     <= 1'b0;
      r_lap_val <= '0;
    end else begin
      r_state <= w_next;
      r_flags <= flags_for(w_next);
      if (w_lap_set) begin
        r_lap     <= 1'b1;
        r_lap_val <= cnt_events;
      end else if (w_lap_clr) begin
        r_lap <= 1'b0;
      end
    end
  end

  // Tick decision follows the current state, so a wrap on the pause edge still fires.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        RUNNING: begin
          if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        PAUSED:  r_presc <= r_presc;
        default: r_presc <= '0;
      endcase
    end
  end

  assign flags        = r_flags;
  assign active_event = r_tick;
  assign lap_active   = r_lap;
  assign state_o      = r_state;
  assign disp_value   = r_lap ? r_lap_val : cnt_events;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Command sequencer for the stopwatch event counter. Converts two raw push-buttons into the one-hot `flags` command word and a prescaled `active_event` tick that drive the counter. Also provides a lap-freeze display mux over the counter's `cnt_events` output. Sits between the board I/O and the counter instance.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a button level change; ≥2.
- `TICK_DIV`, default 1000: clk cycles per `active_event` pulse while running; ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `btn_a` in 1: start/pause button, raw and asynchronous, active-high.
- `btn_b` in 1: lap/clear button, raw and asynchronous, active-high.
- `cnt_events` in 16: current count from the counter.
- `flags` out 8: command word. 8'h01 start, 8'h02 pause, 8'h04 stop/clear. Registered, level-held.
- `active_event` out 1: one-cycle count tick, registered.
- `disp_value` out 16: value to display.
- `lap_active` out 1: display frozen on a lap value.
- `state_o` out 2: FSM state, 0 IDLE, 1 RUNNING, 2 PAUSED.

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any intermediate mismatch-free sample reloads the debounce count.
  - A one-cycle press pulse (`press_a` / `press_b`) fires on each debounced rising edge. Releases generate nothing.
- FSM, with a registered state:
  - IDLE: `press_a` → RUNNING. `press_b` is ignored.
  - RUNNING: `press_a` → PAUSED. `press_b` toggles lap: if `lap_active`=0, capture `cnt_events` into lap_reg and set `lap_active`; otherwise clear `lap_active`.
  - PAUSED: `press_a` → RUNNING. `press_b` → IDLE and clears `lap_active`.
- Simultaneous `press_a` and `press_b` in the same cycle: `press_a` wins and `press_b` is discarded, including any lap action.
- `flags` is a registered function of the next state: IDLE 8'h04, RUNNING 8'h01, PAUSED 8'h02. No other values are ever driven.
- Prescaler, 0..TICK_DIV-1:
  - Increments only in RUNNING.
  - Holds its value in PAUSED, so a partial period resumes.
  - Clears to 0 in IDLE.
  - `active_event`=1 for exactly one cycle when the prescaler wraps from TICK_DIV-1 to 0 in RUNNING. Never asserted in IDLE or PAUSED.
- `disp_value` = `lap_active` ? lap_reg : `cnt_events` (combinational mux; lap_reg is registered).
- Reset, when `rst`=0 at a clk edge:
  - state IDLE, `flags`=8'h04, `active_event`=0, `lap_active`=0, lap_reg=0, prescaler=0.
  - Synchronizers, debounced levels and debounce counts all 0.
  - Reset mid-operation discards any in-flight press and any partial prescale.
  - `disp_value` then equals `cnt_events`.

## Timing
- Raw button rises and stays high before edge 0. The synchronized level is valid after edge 2. The debounced level rises at edge 2+DEBOUNCE_CYCLES, with the press pulse high during the following cycle.
- State, `flags` and lap update at edge 3+DEBOUNCE_CYCLES.
- Pulses shorter than DEBOUNCE_CYCLES cycles after synchronization produce no press.
- Holding a button produces exactly one press.
- Entering RUNNING from IDLE: the first `active_event` occurs TICK_DIV cycles after the state change.
- Transition RUNNING→PAUSED in the same cycle as a prescaler wrap: that tick is still emitted, decided by the current state.
- Lap capture samples `cnt_events` on the same edge as the FSM update. An `active_event` issued in that cycle is not reflected in the captured value.

## Structure
- Package `stopwatch_pkg`:
  - `sw_state_t` enum {IDLE, RUNNING, PAUSED}, 2 bits.
  - Constants FLAG_START=8'h01, FLAG_PAUSE=8'h02, FLAG_STOP=8'h04.
  - Shared by this block and the counter.
- Sub-module `btn_debounce` (param DEBOUNCE_CYCLES; ports `clk`, `rst`, raw in, level out, press pulse out), instantiated twice.
- FSM, prescaler and lap register stay in `stopwatch_ctrl`.

## Test plan
- Reset with no buttons pressed → `flags`=8'h04, `state_o`=0, `active_event`=0 for 100 cycles; `disp_value` tracks `cnt_events`=16'h1234.
- DEBOUNCE_CYCLES=4, TICK_DIV=5: hold `btn_a` high → `flags`=8'h01 exactly at edge 7. `active_event` pulses every 5 cycles; the first pulse comes 5 cycles after entry.
- Glitch `btn_a` high for 3 synchronized cycles → no state change. Hold it 50 cycles → exactly one transition.
- RUNNING, prescaler=2; press `btn_a` → PAUSED, `flags`=8'h02, no ticks. Press `btn_a` again → first tick after 3 more cycles.
- RUNNING with `cnt_events`=16'd42: press `btn_b` → `lap_active`=1 and `disp_value` holds 42 while `cnt_events` advances. Press `btn_b` again → `disp_value` follows `cnt_events`.
- PAUSED: press both buttons in the same cycle → RUNNING, lap unchanged. Then from PAUSED press `btn_b` alone → IDLE, `flags`=8'h04, `lap_active`=0. Assert `rst`=0 mid-debounce → no press afterward.
